// File: rtl/ovl_parity_scheduler_if.sv
// Requester and shared-checker signal bundle for ovl_parity_scheduler.
// The master side drives requests and the checker's fire vector; the slave side is the scheduler.
interface ovl_parity_scheduler_if #(
  parameter int unsigned width   = 8,
  parameter int unsigned num_req = 4
);
  logic                       enable;
  logic [num_req-1:0]         req;
  logic [num_req*width-1:0]   req_data;
  logic                       clr;
  logic [2:0]                 chk_fire;
  logic                       chk_enable;
  logic [width-1:0]           chk_expr;
  logic [num_req-1:0]         grant;
  logic [num_req-1:0]         done;
  logic [num_req-1:0]         err_sticky;
  logic [num_req-1:0]         starve;
  logic [2:0]                 fire;

  modport master (
    output enable, req, req_data, clr, chk_fire,
    input  chk_enable, chk_expr, grant, done, err_sticky, starve, fire
  );

  modport slave (
    input  enable, req, req_data, clr, chk_fire,
    output chk_enable, chk_expr, grant, done, err_sticky, starve, fire
  );
endinterface

// File: rtl/ovl_parity_scheduler.sv
// Round-robin scheduler sharing one even-parity checker among num_req requesters.
// Define OVL_PARITY_SCHED_WDOG_EN to add per-requester starvation watchdogs.
module ovl_parity_scheduler #(
  parameter int unsigned width    = 8,
  parameter int unsigned num_req  = 4,
  parameter int unsigned max_wait = 16
) (
  input logic                   clock,
  input logic                   reset,
  ovl_parity_scheduler_if.slave bus
);
  localparam int unsigned IdxW = $clog2(num_req);

  typedef enum logic [1:0] {StIdle, StIssue, StSample} state_e;

  state_e               state_q;
  logic [IdxW-1:0]      rr_ptr_q;
  logic [IdxW-1:0]      win_idx;
  logic                 found;
  logic [num_req-1:0]   grant_q;
  logic [num_req-1:0]   done_q;
  logic [num_req-1:0]   err_sticky_q;
  logic [num_req-1:0]   err_set;
  logic                 chk_enable_q;
  logic [2:0]           fire_q;
  logic [width-1:0]     chk_expr;
  logic                 unused_chk_fire;

  assign unused_chk_fire = ^bus.chk_fire[2:1];

  // First requesting index at or after rr_ptr_q, wrapping.
  always_comb begin
    found   = 1'b0;
    win_idx = '0;
    for (int unsigned k = 0; k < num_req; k++) begin
      int unsigned idx;
      idx = (32'(rr_ptr_q) + k) % num_req;
      if (!found && bus.req[idx]) begin
        found   = 1'b1;
        win_idx = IdxW'(idx);
      end
    end
  end

  always_comb begin
    err_set = '0;
    if (state_q == StSample && bus.chk_fire[0]) err_set = grant_q;
  end

  always_comb begin
    chk_expr = '0;
    if (state_q == StIssue) begin
      for (int unsigned i = 0; i < num_req; i++) begin
        if (grant_q[i]) chk_expr = bus.req_data[i*width +: width];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q      <= StIdle;
      rr_ptr_q     <= '0;
      grant_q      <= '0;
      chk_enable_q <= 1'b0;
      done_q       <= '0;
      fire_q       <= '0;
      err_sticky_q <= '0;
    end else begin
      done_q       <= '0;
      fire_q       <= '0;
      // A violation landing in the same cycle as clr keeps its bit set.
      err_sticky_q <= (err_sticky_q & ~{num_req{bus.clr}}) | err_set;
      unique case (state_q)
        StIdle: begin
          if (bus.enable && found) begin
            state_q          <= StIssue;
            grant_q          <= '0;
            grant_q[win_idx] <= 1'b1;
            chk_enable_q     <= 1'b1;
            rr_ptr_q         <= (32'(win_idx) == num_req - 1) ? '0 : win_idx + 1'b1;
          end
        end
        StIssue: begin
          state_q      <= StSample;
          chk_enable_q <= 1'b0;
        end
        StSample: begin
          state_q <= StIdle;
          grant_q <= '0;
          done_q  <= grant_q;
          fire_q  <= {1'b1, 1'b0, bus.chk_fire[0]};
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.grant      = grant_q;
  assign bus.done       = done_q;
  assign bus.err_sticky = err_sticky_q;
  assign bus.chk_enable = chk_enable_q;
  assign bus.chk_expr   = chk_expr;
  assign bus.fire       = fire_q;

`ifdef OVL_PARITY_SCHED_WDOG_EN
  logic [num_req-1:0][7:0] wait_cnt_q;
  logic [num_req-1:0]      starve_q;

  always_ff @(posedge clock) begin
    if (!reset) begin
      wait_cnt_q <= '0;
      starve_q   <= '0;
    end else begin
      for (int unsigned i = 0; i < num_req; i++) begin
        if (grant_q[i]) begin
          wait_cnt_q[i] <= '0;
        end else if (bus.req[i] && wait_cnt_q[i] != 8'hff) begin
          wait_cnt_q[i] <= wait_cnt_q[i] + 8'd1;
        end
        // Set on the increment that reaches the threshold; set beats clr.
        if (!grant_q[i] && bus.req[i] && wait_cnt_q[i] != 8'hff &&
            wait_cnt_q[i] + 8'd1 == 8'(max_wait)) begin
          starve_q[i] <= 1'b1;
        end else if (bus.clr) begin
          starve_q[i] <= 1'b0;
        end
      end
    end
  end

  assign bus.starve = starve_q;
`else
  localparam int unsigned unused_max_wait = max_wait;
  assign bus.starve = '0;
`endif
endmodule
